// File: rtl/siaa_pkg.sv
// Shared types and instruction-field constants for the fetch path.
package siaa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int INST_W      = 9;
  localparam int OP_TYPE_BIT = 8;
  localparam logic [2:0] OP_TERM = 3'd6;

  // Terminate is an I-type word (op_type bit set) carrying the terminate opcode.
  function automatic logic is_terminate(input logic op_type, input logic [2:0] opcode);
    return op_type && (opcode == OP_TERM);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and control-decoder signals seen by the fetch unit.
interface fetch_unit_if #(
  parameter int PC_W = 10
);
  import siaa_pkg::*;

  logic [PC_W-1:0]   im_addr;
  logic [INST_W-1:0] im_data;
  logic [INST_W-1:0] inst;
  logic              inst_valid;
  logic              branch;
  logic              branch_taken;
  logic [PC_W-1:0]   target;

  // No handshake: im_data is a combinational read of im_addr, and inst is
  // meaningful only in cycles where inst_valid is 1.
  modport master (
    output im_addr, inst, inst_valid,
    input  im_data, branch, branch_taken, target
  );

  modport slave (
    input  im_addr, inst, inst_valid,
    output im_data, branch, branch_taken, target
  );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: load beats increment, otherwise hold.
module pc_reg #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= PC_W'(START_ADDR);
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch sequencer: IDLE/RUN/DONE FSM, PC steering and saturating RUN-cycle counter.
module fetch_unit
  import siaa_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_count,
  output state_t            fsm_state,
  fetch_unit_if.master      bus
);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc;
  logic            pc_load;
  logic [PC_W-1:0] pc_load_val;
  logic            pc_inc;
  logic            cnt_clear;
  logic            term;

  pc_reg #(
    .PC_W       (PC_W),
    .START_ADDR (START_ADDR)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clear) begin
      cycle_count <= '0;
    end else if (state == RUN && cycle_count != {CNT_W{1'b1}}) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end

  // Outputs depend only on registered state and im_data, never on start/stall.
  assign bus.im_addr    = pc;
  assign bus.inst_valid = (state == RUN);
  assign bus.inst       = (state == RUN) ? bus.im_data : '0;
  assign done           = (state == DONE);
  assign fsm_state      = state;
  assign term           = is_terminate(bus.inst[OP_TYPE_BIT], bus.inst[2:0]);

  always_comb begin
    state_nxt   = state;
    pc_load     = 1'b0;
    pc_load_val = PC_W'(START_ADDR);
    pc_inc      = 1'b0;
    cnt_clear   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          pc_load   = 1'b1;
          cnt_clear = 1'b1;
        end
      end
      RUN: begin
        if (stall) begin
          state_nxt = RUN;
        end else if (term) begin
          state_nxt = DONE;
        end else if (bus.branch && bus.branch_taken) begin
          pc_load     = 1'b1;
          pc_load_val = bus.target;
        end else begin
          pc_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; a second instance with a 3-bit counter checks saturation.
module tb_fetch_unit;
  import siaa_pkg::*;

  localparam int PC_W = 10;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        done, done3;
  logic [15:0] cycle_count;
  logic [2:0]  cycle_count3;
  state_t      fsm_state, fsm_state3;
  logic [8:0]  mem [1024];
  int          n_checks;
  int          n_errors;

  fetch_unit_if #(.PC_W(PC_W)) bus ();
  fetch_unit_if #(.PC_W(PC_W)) bus3 ();

  assign bus.im_data       = mem[bus.im_addr];
  assign bus3.im_data      = mem[bus3.im_addr];
  assign bus3.branch       = bus.branch;
  assign bus3.branch_taken = bus.branch_taken;
  assign bus3.target       = bus.target;

  fetch_unit #(.PC_W(PC_W), .START_ADDR(0), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stall       (stall),
    .done        (done),
    .cycle_count (cycle_count),
    .fsm_state   (fsm_state),
    .bus         (bus.master)
  );

  fetch_unit #(.PC_W(PC_W), .START_ADDR(0), .CNT_W(3)) dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stall       (stall),
    .done        (done3),
    .cycle_count (cycle_count3),
    .fsm_state   (fsm_state3),
    .bus         (bus3.master)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int pc, input int cnt,
                            input state_t st, input logic [8:0] ins);
    check({tag, ".addr"},  32'(bus.im_addr), pc);
    check({tag, ".cnt"},   32'(cycle_count), cnt);
    check({tag, ".cnt3"},  32'(cycle_count3), (cnt > 7) ? 7 : cnt);
    check({tag, ".state"}, 32'(fsm_state), 32'(st));
    check({tag, ".valid"}, 32'(bus.inst_valid), (st == RUN) ? 1 : 0);
    check({tag, ".done"},  32'(done), (st == DONE) ? 1 : 0);
    check({tag, ".inst"},  32'(bus.inst), 32'(ins));
  endtask

  task automatic drive_branch(input logic br, input logic tk, input logic [9:0] tgt);
    bus.branch       = br;
    bus.branch_taken = tk;
    bus.target       = tgt;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 9'h000;
    mem[5]  = 9'h0A5;
    mem[7]  = 9'h0AE;   // opcode 6 but op_type 0: not a terminate
    mem[8]  = 9'h105;   // op_type 1 but opcode 5: not a terminate
    mem[9]  = 9'h106;   // terminate
    mem[40] = 9'h123;
    mem[12] = 9'h0C3;
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    drive_branch(1'b0, 1'b0, 10'd0);
    tick();
    tick();
    expect_out("reset", 0, 0, IDLE, 9'h000);

    rst_n = 1'b1;
    tick();
    expect_out("idle_hold", 0, 0, IDLE, 9'h000);

    // Launch and straight-line fetch
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_out("run_pc0", 0, 0, RUN, 9'h000);
    tick();
    expect_out("run_pc1", 1, 1, RUN, 9'h000);
    tick();
    expect_out("run_pc2", 2, 2, RUN, 9'h000);
    start = 1'b1;         // ignored while running
    tick();
    start = 1'b0;
    expect_out("start_in_run", 3, 3, RUN, 9'h000);
    tick();
    expect_out("run_pc4", 4, 4, RUN, 9'h000);
    tick();
    expect_out("run_pc5", 5, 5, RUN, 9'h0A5);

    // Branch not taken, then taken branches with no bubble
    drive_branch(1'b1, 1'b0, 10'd40);
    tick();
    expect_out("br_not_taken", 6, 6, RUN, 9'h000);
    drive_branch(1'b1, 1'b1, 10'd5);
    tick();
    expect_out("br_back_to5", 5, 7, RUN, 9'h0A5);
    drive_branch(1'b1, 1'b1, 10'd40);
    tick();
    expect_out("br_taken40", 40, 8, RUN, 9'h123);
    drive_branch(1'b1, 1'b1, 10'd7);
    tick();
    expect_out("br_taken7", 7, 9, RUN, 9'h0AE);

    // Stall three cycles at PC 7; stall also outranks the taken branch
    stall = 1'b1;
    drive_branch(1'b1, 1'b1, 10'd100);
    tick();
    expect_out("stall1", 7, 10, RUN, 9'h0AE);
    tick();
    expect_out("stall2", 7, 11, RUN, 9'h0AE);
    tick();
    expect_out("stall3", 7, 12, RUN, 9'h0AE);
    stall = 1'b0;
    drive_branch(1'b1, 1'b0, 10'd100);
    tick();
    expect_out("after_stall", 8, 13, RUN, 9'h105);
    drive_branch(1'b0, 1'b0, 10'd0);
    tick();
    expect_out("at_term", 9, 14, RUN, 9'h106);

    // Terminate with a taken branch on the same word: terminate wins
    drive_branch(1'b1, 1'b1, 10'd40);
    tick();
    drive_branch(1'b0, 1'b0, 10'd0);
    expect_out("done", 9, 15, DONE, 9'h000);
    stall = 1'b1;
    tick();
    stall = 1'b0;
    expect_out("done_hold", 9, 15, DONE, 9'h000);

    // Relaunch from DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_out("relaunch", 0, 0, RUN, 9'h000);

    // PC wrap at the top of the address space
    drive_branch(1'b1, 1'b1, 10'd1023);
    tick();
    drive_branch(1'b0, 1'b0, 10'd0);
    expect_out("pc_max", 1023, 1, RUN, 9'h000);
    tick();
    expect_out("pc_wrap", 0, 2, RUN, 9'h000);

    // Reset mid-run dominates start, stall and branch
    drive_branch(1'b1, 1'b1, 10'd12);
    tick();
    expect_out("run_pc12", 12, 3, RUN, 9'h0C3);
    rst_n = 1'b0;
    start = 1'b1;
    stall = 1'b1;
    drive_branch(1'b1, 1'b1, 10'd40);
    tick();
    expect_out("reset_mid_run", 0, 0, IDLE, 9'h000);
    rst_n = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    drive_branch(1'b0, 1'b0, 10'd0);
    tick();
    expect_out("idle_after_rst", 0, 0, IDLE, 9'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 10, program counter and instruction-memory address width.
REQ-002 Parameter START_ADDR, default 0, PC value loaded on every launch.
REQ-003 Parameter CNT_W, default 16, cycle-counter width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  single-cycle launch request; honoured only in IDLE or DONE.
REQ-007 stall  input  1  hold PC and the current instruction.
REQ-008 branch  input  1  control-decoder branch strobe for the current instruction.
REQ-009 branch_taken  input  1  branch condition; the redirect occurs only when branch and branch_taken are both 1.
REQ-010 target  input  PC_W  redirect address.
REQ-011 im_addr  output  PC_W  instruction-memory address; equals PC.
REQ-012 im_data  input  9  instruction word; combinational read of im_addr.
REQ-013 inst  output  9  instruction to the control decoder; equals im_data while inst_valid is 1, 9'h000 otherwise.
REQ-014 inst_valid  output  1  high only in RUN.
REQ-015 done  output  1  high only in DONE.
REQ-016 cycle_count  output  CNT_W  number of RUN cycles since the last launch.

Function
REQ-017 FSM states: IDLE, RUN, DONE.
REQ-018 IDLE: start=1 -> RUN next cycle; PC<=START_ADDR; cycle_count<=0.
REQ-019 RUN, stall=1: PC held, FSM held, terminate detection suppressed; cycle_count still increments.
REQ-020 RUN, stall=0, terminate decoded (inst[8]=1 and inst[2:0]=3'd6): DONE next cycle; PC held at the terminate address.
REQ-021 RUN, stall=0, not terminate, branch and branch_taken both 1: PC<=target.
REQ-022 RUN, stall=0, otherwise: PC<=PC+1, modulo 2^PC_W; address 2^PC_W-1 wraps to 0.
REQ-023 Priority in RUN: stall > terminate > taken branch > increment.
REQ-024 A terminate word that also carries branch=1 terminates; the branch is ignored.
REQ-025 start while in RUN is ignored.
REQ-026 DONE: outputs held; start=1 -> RUN with PC<=START_ADDR and cycle_count<=0 (relaunch).
REQ-027 cycle_count increments by 1 on every RUN cycle.
REQ-028 cycle_count saturates at 2^CNT_W-1 and never wraps.
REQ-029 cycle_count is held in IDLE and DONE.
REQ-030 Fetch latency: the instruction at the new PC appears on inst in the cycle after any PC update; there is no bubble on a taken branch.
REQ-031 inst, inst_valid and done are functions of registered state and im_data only; no output depends combinationally on start or stall.

Reset
REQ-032 rst_n=0 at a clock edge forces IDLE, PC=START_ADDR, cycle_count=0, inst_valid=0, done=0, inst=9'h000, from any state including mid-RUN.
REQ-033 rst_n=0 dominates start, stall and branch in the same cycle.

Structure
REQ-034 Shared package siaa_pkg holds the FSM state enum (IDLE, RUN, DONE), the I-type terminate opcode constant (3'd6), the instruction-width constant (9) and the op_type bit index (8).
REQ-035 One sub-module, pc_reg: the PC register with hold, load and increment controls.
REQ-036 All FSM and counter logic stays in fetch_unit.

Verification
REQ-037 Reset, then start pulse, im_data = 9'h000 at addresses 0..4 -> im_addr sequence 0,1,2,3,4 on consecutive cycles; inst_valid=1 from the cycle after start.
REQ-038 At PC=5, branch=1, branch_taken=1, target=10'd40 -> next im_addr=40.
REQ-039 At PC=5, branch=1, branch_taken=0 -> next im_addr=6.
REQ-040 stall held high for 3 cycles at PC=7 -> im_addr stays 7 for those 3 cycles; cycle_count advances by 3.
REQ-041 9'h106 at address 9 -> done=1 next cycle; inst_valid=0; im_addr=9; cycle_count frozen.
REQ-042 Start pulse in DONE -> im_addr=0 and cycle_count=0.
REQ-043 PC=1023 with no branch -> next im_addr=0.
REQ-044 rst_n=0 during RUN at PC=12 -> next cycle IDLE, im_addr=0, done=0, inst_valid=0, cycle_count=0.
